// File: rtl/keypad_scan_ctrl_if.sv
// Keypad pin and key-code bundle between the scan controller (master) and its
// board-side environment (slave).
interface keypad_scan_ctrl_if;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] onehot;
  logic        key_valid;
  logic        key_held;

  modport master (
    input  row_in,
    output col_out,
    output onehot,
    output key_valid,
    output key_held
  );

  modport slave (
    output row_in,
    input  col_out,
    input  onehot,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner with press/release debouncing; drives the columns and
// presents a registered one-hot key code, a new-key strobe and a held flag.
module keypad_scan_ctrl #(
  parameter int CLK_DIV      = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  keypad_scan_ctrl_if.master  kp
);

  localparam int                DIV_W   = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]        DEB_MAX = 4'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {
    SCAN,
    DEB_PRESS,
    PRESSED,
    DEB_RELEASE
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [3:0]        deb_q, deb_d;
  logic [3:0]        row_s1_q, row_s1_d;
  logic [3:0]        row_s2_q, row_s2_d;
  logic [3:0]        cap_row_q, cap_row_d;
  logic [1:0]        cap_col_q, cap_col_d;
  logic [3:0]        col_q, col_d;
  logic [15:0]       onehot_q, onehot_d;
  logic              valid_q, valid_d;
  logic              held_q, held_d;

  logic              tick;
  logic              all_high;
  logic              single_low;
  logic [3:0]        col_rot;
  logic [3:0]        deb_inc;

  // Position of the single low bit in an active-low one-cold vector.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    case (v)
      4'b1110: low_index = 2'd0;
      4'b1101: low_index = 2'd1;
      4'b1011: low_index = 2'd2;
      default: low_index = 2'd3;
    endcase
  endfunction

  always_comb begin
    row_s1_d   = kp.row_in;
    row_s2_d   = row_s1_q;
    state_d    = state_q;
    deb_d      = deb_q;
    cap_row_d  = cap_row_q;
    cap_col_d  = cap_col_q;
    col_d      = col_q;
    onehot_d   = onehot_q;
    valid_d    = 1'b0;
    held_d     = held_q;

    tick       = (div_q == DIV_MAX);
    div_d      = tick ? '0 : div_q + DIV_W'(1);
    all_high   = (row_s2_q == 4'b1111);
    single_low = (row_s2_q == 4'b1110) || (row_s2_q == 4'b1101) ||
                 (row_s2_q == 4'b1011) || (row_s2_q == 4'b0111);
    col_rot    = {col_q[2:0], col_q[3]};
    deb_inc    = deb_q + 4'd1;

    // Ghosted patterns (two or more rows low) never match the single-row test.
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (single_low) begin
            cap_row_d = row_s2_q;
            cap_col_d = low_index(col_q);
            deb_d     = 4'd0;
            state_d   = DEB_PRESS;
          end else begin
            col_d = col_rot;
          end
        end
        DEB_PRESS: begin
          if (row_s2_q == cap_row_q) begin
            deb_d = deb_inc;
            if (deb_inc == DEB_MAX) begin
              state_d  = PRESSED;
              onehot_d = 16'd1 << {cap_col_q, low_index(cap_row_q)};
              valid_d  = 1'b1;
              held_d   = 1'b1;
            end
          end else begin
            state_d = SCAN;
            col_d   = col_rot;
          end
        end
        PRESSED: begin
          if (all_high) begin
            deb_d   = 4'd0;
            state_d = DEB_RELEASE;
          end
        end
        DEB_RELEASE: begin
          if (all_high) begin
            deb_d = deb_inc;
            if (deb_inc == DEB_MAX) begin
              held_d  = 1'b0;
              state_d = SCAN;
              col_d   = col_rot;
            end
          end else begin
            state_d = PRESSED;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= SCAN;
      div_q     <= '0;
      deb_q     <= 4'd0;
      row_s1_q  <= 4'b1111;
      row_s2_q  <= 4'b1111;
      cap_row_q <= 4'b1111;
      cap_col_q <= 2'd0;
      col_q     <= 4'b1110;
      onehot_q  <= 16'h0000;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      deb_q     <= deb_d;
      row_s1_q  <= row_s1_d;
      row_s2_q  <= row_s2_d;
      cap_row_q <= cap_row_d;
      cap_col_q <= cap_col_d;
      col_q     <= col_d;
      onehot_q  <= onehot_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
    end
  end

  assign kp.col_out   = col_q;
  assign kp.onehot    = onehot_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a simple matrix keypad model
// (one key plus an optional ghost pattern) wired back from col_out to row_in.
module tb_keypad_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  int total = 0;
  int bad = 0;
  int vld_count = 0;

  logic       key_on = 1'b0;
  logic [1:0] key_row = 2'd0;
  logic [1:0] key_col = 2'd0;
  logic       ghost_on = 1'b0;
  logic [3:0] rows;

  keypad_scan_ctrl_if kif();

  keypad_scan_ctrl #(
    .CLK_DIV      (4),
    .DEBOUNCE_CNT (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kif.master)
  );

  always #5 clk = ~clk;

  // A pressed key pulls its row low only while its column is driven low.
  always_comb begin
    rows = 4'b1111;
    if (key_on && (kif.col_out[key_col] == 1'b0))
      rows[key_row] = 1'b0;
    if (ghost_on && (kif.col_out == 4'b1101))
      rows = 4'b0011;
  end
  assign kif.row_in = rows;

  always @(negedge clk) begin
    if (kif.key_valid === 1'b1)
      vld_count++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic apply_stimulus(input logic on, input logic [1:0] row, input logic [1:0] col);
    key_row = row;
    key_col = col;
    key_on  = on;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      $error("[TB] check %s differs", tag);
    end
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while ((n < limit) && (kif.key_valid !== 1'b1)) begin
      wait_cycles(1);
      n++;
    end
  endtask

  task automatic check_rotation(input string tag);
    logic [3:0] c0;
    c0 = kif.col_out;
    wait_cycles(4);
    check_output(tag, kif.col_out, {c0[2:0], c0[3]});
  endtask

  initial begin
    int n;

    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check_output("reset_col", kif.col_out, 4'b1110);
    check_output("reset_onehot", kif.onehot, 16'h0000);
    check_output("reset_valid", kif.key_valid, 1'b0);
    check_output("reset_held", kif.key_held, 1'b0);
    rst_n = 1'b1;

    wait_cycles(3);
    check_output("scan_hold_col0", kif.col_out, 4'b1110);
    wait_cycles(1);
    check_output("scan_col1", kif.col_out, 4'b1101);
    wait_cycles(4);
    check_output("scan_col2", kif.col_out, 4'b1011);
    wait_cycles(4);
    check_output("scan_col3", kif.col_out, 4'b0111);
    wait_cycles(4);
    check_output("scan_wrap_col0", kif.col_out, 4'b1110);

    // Clean press row 3 / col 2: column reaches col 2 eight cycles later,
    // two sync cycles, capture tick, three matching ticks, one register stage.
    apply_stimulus(1'b1, 2'd3, 2'd2);
    wait_valid(100, n);
    check_output("press_latency", n, 24);
    check_output("press_onehot", kif.onehot, 16'h0800);
    check_output("press_held", kif.key_held, 1'b1);
    check_output("press_col_frozen", kif.col_out, 4'b1011);
    wait_cycles(1);
    check_output("press_valid_one_cycle", kif.key_valid, 1'b0);
    wait_cycles(15);
    check_output("press_still_held", kif.key_held, 1'b1);
    check_output("press_col_still_frozen", kif.col_out, 4'b1011);
    check_output("press_single_pulse", vld_count, 1);

    apply_stimulus(1'b0, 2'd3, 2'd2);
    wait_cycles(24);
    check_output("release1_held", kif.key_held, 1'b0);
    check_output("release1_onehot", kif.onehot, 16'h0800);

    // Bouncing row 1 / col 0: key flips every tick, then settles pressed.
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(~i[0], 2'd1, 2'd0);
      wait_cycles(4);
    end
    check_output("bounce_no_valid", vld_count, 1);
    apply_stimulus(1'b1, 2'd1, 2'd0);
    wait_valid(200, n);
    check_output("bounce_accepted", kif.key_valid, 1'b1);
    check_output("bounce_onehot", kif.onehot, 16'h0002);
    check_output("bounce_held", kif.key_held, 1'b1);
    wait_cycles(2);
    check_output("bounce_pulse_count", vld_count, 2);

    // Short release of two ticks falls back to PRESSED without a new strobe.
    apply_stimulus(1'b0, 2'd1, 2'd0);
    wait_cycles(8);
    apply_stimulus(1'b1, 2'd1, 2'd0);
    wait_cycles(24);
    check_output("repress_held", kif.key_held, 1'b1);
    check_output("repress_no_valid", vld_count, 2);
    check_output("repress_col_frozen", kif.col_out, 4'b1110);

    apply_stimulus(1'b0, 2'd1, 2'd0);
    wait_cycles(28);
    check_output("release2_held", kif.key_held, 1'b0);
    check_output("release2_onehot", kif.onehot, 16'h0002);
    check_output("release2_no_valid", vld_count, 2);
    check_rotation("release2_scan_resumes");

    ghost_on = 1'b1;
    wait_cycles(40);
    check_output("ghost_no_valid", vld_count, 2);
    check_output("ghost_held", kif.key_held, 1'b0);
    check_output("ghost_onehot", kif.onehot, 16'h0002);
    check_rotation("ghost_rotates");
    ghost_on = 1'b0;

    // Reset while debouncing row 2 / col 3.
    n = 0;
    while ((n < 40) && (kif.col_out == 4'b0111)) begin
      wait_cycles(1);
      n++;
    end
    apply_stimulus(1'b1, 2'd2, 2'd3);
    n = 0;
    while ((n < 40) && (kif.col_out != 4'b0111)) begin
      wait_cycles(1);
      n++;
    end
    check_output("middeb_reached_col3", kif.col_out, 4'b0111);
    wait_cycles(6);
    rst_n = 1'b0;
    wait_cycles(1);
    check_output("middeb_reset_col", kif.col_out, 4'b1110);
    check_output("middeb_reset_onehot", kif.onehot, 16'h0000);
    check_output("middeb_reset_valid", kif.key_valid, 1'b0);
    check_output("middeb_reset_held", kif.key_held, 1'b0);
    wait_cycles(2);
    apply_stimulus(1'b0, 2'd2, 2'd3);
    rst_n = 1'b1;
    wait_cycles(40);
    check_output("middeb_no_valid", vld_count, 2);
    check_output("middeb_onehot_clear", kif.onehot, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
